// File: rtl/pcm_ram_arb.sv
// Single-port word array shared by a CPU port (read/write) and an engine port (read-only),
// with round-robin arbitration and an optional zero-fill sweep after reset.
module pcm_ram_arb #(
    parameter int DW           = 8,
    parameter int AW           = 10,
    parameter int RD_LAT       = 1,
    parameter int CLR_ON_RESET = 1
) (
    input  logic          CLK,
    input  logic          nRESET,
    input  logic          A_REQ,
    input  logic          A_WE,
    input  logic [AW-1:0] A_ADDR,
    input  logic [DW-1:0] A_WDATA,
    output logic          A_ACK,
    output logic          A_RVALID,
    output logic [DW-1:0] A_RDATA,
    input  logic          B_REQ,
    input  logic [AW-1:0] B_ADDR,
    output logic          B_ACK,
    output logic          B_RVALID,
    output logic [DW-1:0] B_RDATA,
    output logic          BUSY
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    localparam state_t ST_RESET = (CLR_ON_RESET == 1) ? ST_CLEAR : ST_SERVE;

    state_t        state_r, state_nxt_s;
    logic [AW-1:0] cnt_r, cnt_nxt_s;
    logic          last_b_r, last_b_nxt_s;
    logic          grant_a_s, grant_b_s;
    logic          a_ack_s, b_ack_s;

    logic [DW-1:0] mem_r [DEPTH];
    logic          wr_en_s;
    logic [AW-1:0] wr_addr_s;
    logic [DW-1:0] wr_data_s;
    logic          rd_en_s;
    logic          rd_port_s;
    logic [AW-1:0] rd_addr_s;
    logic [DW-1:0] rd_data_s;

    logic          iss_v_s;
    logic          iss_port_s;
    logic [DW-1:0] iss_data_s;

    logic          a_rvalid_r, b_rvalid_r;
    logic [DW-1:0] a_rdata_r, b_rdata_r;

    // State, sweep counter and arbiter history registers
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_r  <= ST_RESET;
            cnt_r    <= {AW{1'b0}};
            last_b_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            last_b_r <= last_b_nxt_s;
        end
    end

    // Next-state, grant and array access selection
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        last_b_nxt_s = last_b_r;
        grant_a_s    = 1'b0;
        grant_b_s    = 1'b0;
        wr_en_s      = 1'b0;
        wr_addr_s    = cnt_r;
        wr_data_s    = {DW{1'b0}};
        rd_en_s      = 1'b0;
        rd_port_s    = 1'b0;
        rd_addr_s    = A_ADDR;
        case (state_r)
            ST_CLEAR: begin
                wr_en_s = nRESET;
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_SERVE;
                    cnt_nxt_s   = {AW{1'b0}};
                end else begin
                    cnt_nxt_s   = cnt_r + AW'(1'b1);
                end
            end
            ST_SERVE: begin
                // On a tie the port that did not win last time goes first
                if (A_REQ && B_REQ) begin
                    grant_a_s = last_b_r;
                    grant_b_s = ~last_b_r;
                end else begin
                    grant_a_s = A_REQ;
                    grant_b_s = B_REQ;
                end
                grant_a_s = grant_a_s & nRESET;
                grant_b_s = grant_b_s & nRESET;
                if (grant_a_s) begin
                    last_b_nxt_s = 1'b0;
                    if (A_WE) begin
                        wr_en_s   = 1'b1;
                        wr_addr_s = A_ADDR;
                        wr_data_s = A_WDATA;
                    end else begin
                        rd_en_s   = 1'b1;
                        rd_port_s = 1'b0;
                        rd_addr_s = A_ADDR;
                    end
                end else if (grant_b_s) begin
                    last_b_nxt_s = 1'b1;
                    rd_en_s      = 1'b1;
                    rd_port_s    = 1'b1;
                    rd_addr_s    = B_ADDR;
                end else begin
                    last_b_nxt_s = last_b_r;
                end
            end
            default: begin
                state_nxt_s = ST_RESET;
                cnt_nxt_s   = {AW{1'b0}};
            end
        endcase
        a_ack_s = grant_a_s;
        b_ack_s = grant_b_s;
    end

    // Storage array; deliberately not reset, only the sweep clears it
    always_ff @(posedge CLK) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Read sees the word before any write at the same edge
    assign rd_data_s = mem_r[rd_addr_s];

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic          s1_v_r;
            logic          s1_port_r;
            logic [DW-1:0] s1_data_r;

            // Extra read pipeline stage for two-cycle latency
            always_ff @(posedge CLK or negedge nRESET) begin
                if (!nRESET) begin
                    s1_v_r    <= 1'b0;
                    s1_port_r <= 1'b0;
                    s1_data_r <= {DW{1'b0}};
                end else begin
                    s1_v_r    <= rd_en_s;
                    s1_port_r <= rd_port_s;
                    s1_data_r <= rd_data_s;
                end
            end

            assign iss_v_s    = s1_v_r;
            assign iss_port_s = s1_port_r;
            assign iss_data_s = s1_data_r;
        end else begin : g_lat1
            assign iss_v_s    = rd_en_s;
            assign iss_port_s = rd_port_s;
            assign iss_data_s = rd_data_s;
        end
    endgenerate

    // Read return registers; data holds between valid pulses
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            a_rvalid_r <= 1'b0;
            b_rvalid_r <= 1'b0;
            a_rdata_r  <= {DW{1'b0}};
            b_rdata_r  <= {DW{1'b0}};
        end else begin
            a_rvalid_r <= iss_v_s & ~iss_port_s;
            b_rvalid_r <= iss_v_s & iss_port_s;
            if (iss_v_s && !iss_port_s) begin
                a_rdata_r <= iss_data_s;
            end
            if (iss_v_s && iss_port_s) begin
                b_rdata_r <= iss_data_s;
            end
        end
    end

    assign A_ACK    = a_ack_s;
    assign B_ACK    = b_ack_s;
    assign A_RVALID = a_rvalid_r;
    assign B_RVALID = b_rvalid_r;
    assign A_RDATA  = a_rdata_r;
    assign B_RDATA  = b_rdata_r;
    assign BUSY     = (state_r == ST_CLEAR);

endmodule
